instr_inject_ctrl: RTL and testbench
====================================

INSTR_INJECT_CTRL -- requirements
Module: instr_inject_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning injection FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4, meaning NOP cycles issued after the last injected instruction (>=1).
REQ-003 SHALL have parameter NOP, default 32'h0000_0013, meaning the instruction word driven when no injected instruction is available.
REQ-004 SHALL provide ports: clk input 1 (sole clock, rising edge); reset input 1 (asynchronous, active-low).
REQ-005 SHALL provide ports: src0_valid input 1, src0_instr input 32, src0_ready output 1 (requester 0 handshake).
REQ-006 SHALL provide ports: src1_valid input 1, src1_instr input 32, src1_ready output 1 (requester 1 handshake).
REQ-007 SHALL provide ports: inj_en input 1 (permit injection); instr_mode output 1 (0=memory, 1=external); instr_ext output 32 (injected word to core).
REQ-008 SHALL provide ports: busy output 1 (state != IDLE); fifo_count output $clog2(DEPTH)+1; issued_count output 16 (injected instructions issued, excluding NOPs).

Function
REQ-009 SHALL accept a word from srcN when srcN_valid & srcN_ready at a rising edge, writing it to the FIFO tail.
REQ-010 SHALL grant at most one source per cycle; srcN_ready = grant_N & FIFO not full (combinational from valids and registered state).
REQ-011 SHALL arbitrate round-robin: only one valid -> grant it; both valid -> grant the source not most recently accepted; last-accepted pointer updates only on acceptance.
REQ-012 SHALL deassert both readys when FIFO is full, including a cycle with a simultaneous pop (no full-bypass).
REQ-013 SHALL implement FSM states IDLE, ISSUE, DRAIN; instr_mode and instr_ext registered.
REQ-014 IDLE: instr_mode=0, instr_ext=NOP; on an edge with FIFO non-empty & inj_en -> load head into instr_ext, instr_mode<=1, pop, enter ISSUE.
REQ-015 ISSUE: each edge with FIFO non-empty & inj_en -> load head, pop, increment issued_count; else load NOP, load drain counter with DRAIN_CYCLES-1, enter DRAIN.
REQ-016 DRAIN: instr_mode=1, instr_ext=NOP; edge with FIFO non-empty & inj_en -> load head, pop, enter ISSUE; else counter==0 -> instr_mode<=0, enter IDLE; else decrement.
REQ-017 SHALL hence drive exactly DRAIN_CYCLES consecutive NOP cycles with instr_mode=1 before instr_mode returns to 0.
REQ-018 SHALL produce latency of one cycle: word accepted at edge E, visible on instr_ext after edge E+1 when FSM was IDLE or DRAIN with empty FIFO.
REQ-019 SHALL increment issued_count on every pop (including the IDLE->ISSUE pop), wrapping 16'hFFFF -> 0.
REQ-020 SHALL update fifo_count by +1 on push, -1 on pop, unchanged on simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-021 SHALL preserve FIFO contents while inj_en=0; deasserting inj_en in ISSUE enters DRAIN on the next edge.

Reset
REQ-022 SHALL, while reset=0, asynchronously force state=IDLE, instr_mode=0, instr_ext=NOP, FIFO empty, fifo_count=0, issued_count=0, drain counter=0, round-robin pointer favouring src0 first.
REQ-023 SHALL, on reset asserted mid-ISSUE or mid-DRAIN, discard all queued words and drive instr_mode=0 immediately, without completing the drain.
REQ-024 SHALL hold both readys at 0 while reset=0.

Verification
REQ-025 Single inject: inj_en=1, src0 pushes 32'h00500093 at edge E -> instr_mode=1, instr_ext=32'h00500093 after E+1, then 4 NOP cycles, instr_mode=0; issued_count=1.
REQ-026 Contention: both sources valid continuously with distinct words, FIFO never full -> acceptances alternate src0,src1,src0,...; issue order matches acceptance order.
REQ-027 Full: inj_en=0, push 4 words -> fifo_count=4, both readys 0; set inj_en=1 -> 4 words issued back-to-back in order, then 4 NOPs.
REQ-028 Re-entry: push a new word during 2nd DRAIN cycle -> word issued on next cycle, instr_mode stays 1, full 4-cycle drain restarts afterwards.
REQ-029 Reset mid-operation: reset=0 during ISSUE with fifo_count=3 -> instr_mode=0, instr_ext=NOP, fifo_count=0, issued_count=0 without waiting for clk.
REQ-030 Enable drop: inj_en deasserted in ISSUE with 2 words queued -> DRAIN, 4 NOPs, IDLE, fifo_count stays 2.

Source files
------------

// File: rtl/instr_inject_ctrl.sv
// Instruction injection controller: two requesters feed a FIFO through a
// round-robin arbiter; queued words are issued to the core, followed by a NOP drain.
module instr_inject_ctrl #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter logic [31:0] NOP          = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     src0_valid,
    input  logic [31:0]              src0_instr,
    output logic                     src0_ready,
    input  logic                     src1_valid,
    input  logic [31:0]              src1_instr,
    output logic                     src1_ready,
    input  logic                     inj_en,
    output logic                     instr_mode,
    output logic [31:0]              instr_ext,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              issued_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state_q,   state_d;
    logic          mode_q,    mode_d;
    logic [31:0]   ext_q,     ext_d;
    logic [CW-1:0] drain_q,   drain_d;
    logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [AW:0]   count_q,   count_d;
    logic [15:0]   issued_q,  issued_d;
    logic          last1_q,   last1_d;
    logic [31:0]   mem_q [DEPTH];

    logic        full;
    logic        empty;
    logic        grant0;
    logic        grant1;
    logic        push;
    logic        pop;
    logic [31:0] push_word;
    logic [31:0] head_word;

    // last1_q=1 means src1 was accepted last, so src0 wins the next tie
    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign grant0     = src0_valid & (~src1_valid | last1_q);
    assign grant1     = src1_valid & (~src0_valid | ~last1_q);
    assign src0_ready = reset & grant0 & ~full;
    assign src1_ready = reset & grant1 & ~full;
    assign push       = src0_ready | src1_ready;
    assign push_word  = src0_ready ? src0_instr : src1_instr;
    assign pop        = ~empty & inj_en;
    assign head_word  = mem_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        ext_d    = ext_q;
        drain_d  = drain_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        issued_d = pop  ? issued_q + 16'd1 : issued_q;
        last1_d  = last1_q;
        count_d  = count_q;

        if (src0_ready) begin
            last1_d = 1'b0;
        end else if (src1_ready) begin
            last1_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    ext_d   = head_word;
                    mode_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (pop) begin
                    ext_d = head_word;
                end else begin
                    ext_d   = NOP;
                    drain_d = DRAIN_LOAD;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop) begin
                    ext_d   = head_word;
                    state_d = ST_ISSUE;
                end else if (drain_q == '0) begin
                    mode_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: begin
                mode_d  = 1'b0;
                ext_d   = NOP;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            ext_q    <= NOP;
            drain_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            issued_q <= '0;
            last1_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            ext_q    <= ext_d;
            drain_q  <= drain_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            last1_q  <= last1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign instr_mode   = mode_q;
    assign instr_ext    = ext_q;
    assign busy         = (state_q != ST_IDLE);
    assign fifo_count   = count_q;
    assign issued_count = issued_q;

endmodule

// File: tb/tb_instr_inject_ctrl.sv
// Scoreboard bench for instr_inject_ctrl: a queue-based reference model predicts
// acceptances and issued words; a monitor checks what the DUT presents each cycle.
module tb_instr_inject_ctrl;

    localparam int          DEPTH = 4;
    localparam int          DRAIN = 4;
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        src0_valid, src1_valid, inj_en;
    logic [31:0] src0_instr, src1_instr;
    logic        src0_ready, src1_ready;
    logic        instr_mode, busy;
    logic [31:0] instr_ext;
    logic [2:0]  fifo_count;
    logic [15:0] issued_count;

    instr_inject_ctrl #(
        .DEPTH(DEPTH),
        .DRAIN_CYCLES(DRAIN),
        .NOP(NOP_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .src0_valid(src0_valid),
        .src0_instr(src0_instr),
        .src0_ready(src0_ready),
        .src1_valid(src1_valid),
        .src1_instr(src1_instr),
        .src1_ready(src1_ready),
        .inj_en(inj_en),
        .instr_mode(instr_mode),
        .instr_ext(instr_ext),
        .busy(busy),
        .fifo_count(fifo_count),
        .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queued words, issued-word scoreboard, mode / NOP-run tracking
    logic [31:0] m_fifo[$];
    logic [31:0] exp_q[$];
    bit          m_last1;
    bit          m_mode;
    bit          m_word;
    int          m_nops;
    logic [15:0] m_issued;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] r;
        r = $urandom;
        r[31] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_last1  = 1'b1;
        m_mode   = 1'b0;
        m_word   = 1'b0;
        m_nops   = 0;
        m_issued = '0;
    endtask

    // One clock cycle: drive at negedge, check readys, advance the model at posedge
    task automatic cyc(input bit v0, input logic [31:0] w0,
                       input bit v1, input logic [31:0] w1, input bit en);
        bit g0, g1, full, pop, er0, er1;
        @(negedge clk);
        src0_valid = v0;
        src0_instr = w0;
        src1_valid = v1;
        src1_instr = w1;
        inj_en     = en;
        g0   = v0 && (!v1 || m_last1);
        g1   = v1 && (!v0 || !m_last1);
        full = (m_fifo.size() == DEPTH);
        er0  = reset && g0 && !full;
        er1  = reset && g1 && !full;
        #1;
        check("src0_ready", 32'(src0_ready), 32'(er0));
        check("src1_ready", 32'(src1_ready), 32'(er1));
        @(posedge clk);
        if (reset) begin
            pop = (m_fifo.size() != 0) && en;
            if (pop) begin
                exp_q.push_back(m_fifo.pop_front());
                m_mode = 1'b1;
                m_word = 1'b1;
                m_nops = 0;
                m_issued = m_issued + 16'd1;
            end else if (m_mode && m_nops < DRAIN) begin
                m_word = 1'b0;
                m_nops++;
            end else begin
                m_mode = 1'b0;
                m_word = 1'b0;
            end
            if (er0) begin
                m_fifo.push_back(w0);
                m_last1 = 1'b0;
            end else if (er1) begin
                m_fifo.push_back(w1);
                m_last1 = 1'b1;
            end
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        src0_valid = 1'b1;
        src1_valid = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_instr_mode", 32'(instr_mode), 32'd0);
        check("rst_instr_ext", instr_ext, NOP_W);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_issued_count", 32'(issued_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_src0_ready", 32'(src0_ready), 32'd0);
        check("rst_src1_ready", 32'(src1_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        inj_en     = 1'b0;
        reset      = 1'b1;
    endtask

    always @(posedge clk) begin
        #2;
        check("instr_mode", 32'(instr_mode), 32'(m_mode));
        check("busy", 32'(busy), 32'(m_mode));
        check("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
        check("issued_count", 32'(issued_count), 32'(m_issued));
        check("ext_is_word", 32'(instr_ext != NOP_W), 32'(m_word));
        if (instr_mode && instr_ext != NOP_W) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL issue_word: got %h expected <nothing queued>", instr_ext);
            end else begin
                check("issue_word", instr_ext, exp_q.pop_front());
            end
        end
    end

    initial begin
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        src0_instr = '0;
        src1_instr = '0;
        inj_en     = 1'b0;
        model_reset();
        async_reset();

        // Single inject then a full drain back to memory mode
        cyc(1'b1, 32'h0050_0093, 1'b0, '0, 1'b1);
        repeat (8) cyc(1'b0, '0, 1'b0, '0, 1'b1);
        #2;
        check("single_issued", 32'(issued_count), 32'd1);

        // Contention: both requesters valid every cycle
        repeat (20) cyc(1'b1, rand_word(), 1'b1, rand_word(), 1'b1);
        repeat (8) cyc(1'b0, '0, 1'b0, '0, 1'b1);

        // Fill the FIFO with injection disabled, then release it
        repeat (6) cyc(1'b1, rand_word(), 1'b1, rand_word(), 1'b0);
        #2;
        check("full_fifo_count", 32'(fifo_count), 32'd4);
        repeat (10) cyc(1'b0, '0, 1'b0, '0, 1'b1);

        // Re-entry: new word arrives in the second drain cycle
        cyc(1'b1, rand_word(), 1'b0, '0, 1'b1);
        repeat (3) cyc(1'b0, '0, 1'b0, '0, 1'b1);
        cyc(1'b1, rand_word(), 1'b0, '0, 1'b1);
        repeat (8) cyc(1'b0, '0, 1'b0, '0, 1'b1);

        // Enable drop with two words still queued
        repeat (3) cyc(1'b1, rand_word(), 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (8) cyc(1'b0, '0, 1'b0, '0, 1'b0);
        #2;
        check("drop_fifo_count", 32'(fifo_count), 32'd2);
        check("drop_instr_mode", 32'(instr_mode), 32'd0);
        repeat (10) cyc(1'b0, '0, 1'b0, '0, 1'b1);

        // Reset while issuing with three words queued
        repeat (4) cyc(1'b1, rand_word(), 1'b1, rand_word(), 1'b0);
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        async_reset();

        // Random traffic
        repeat (400) cyc(1'($urandom_range(0, 1)), rand_word(),
                         1'($urandom_range(0, 1)), rand_word(),
                         ($urandom_range(0, 3) != 0));
        repeat (12) cyc(1'b0, '0, 1'b0, '0, 1'b1);
        #3;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
